// File: rtl/nvram_pkg.sv
// Shared types and helpers for the HPS NVRAM upload responder.
package nvram_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHalt    = 3'd1,
        StReady   = 3'd2,
        StFetch   = 3'd3,
        StRelease = 3'd4
    } nvram_state_e;

    localparam logic [7:0] DEFAULT_INDEX = 8'd4;

    // True when a non-empty window [base, base+len) fits inside the RAM address space.
    function automatic bit window_fits(input int unsigned addr_w, input int unsigned base,
                                       input int unsigned len);
        logic [63:0] span;
        span = 64'(base) + 64'(len);
        return (len != 0) && (span <= (64'd1 << addr_w));
    endfunction

endpackage

// File: rtl/nvram_upload_if.sv
// HPS ioctl upload channel as seen by a byte responder.
interface nvram_upload_if;

    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait
    );

endinterface

// File: rtl/nvram_upload_fetch.sv
// Request address latch, window compare, RAM address register and read-latency counter.
module nvram_fetch #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned BASE    = 0,
    parameter int unsigned LEN     = 64,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              latch,
    input  logic              start,
    input  logic              active,
    input  logic [24:0]       addr_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              oow,
    output logic              done
);

    logic [24:0]       off_q;
    logic [24:0]       eff;
    logic              in_win;
    logic              oow_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] ram_addr_q;

    // A request accepted in the same cycle the fetch starts bypasses the latch.
    assign eff    = latch ? addr_in : off_q;
    assign in_win = ({7'd0, eff} < LEN);
    assign done   = active & (oow_q | (cnt_q == 3'(RAM_LAT)));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            off_q      <= '0;
            oow_q      <= 1'b0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
        end else begin
            if (latch) begin
                off_q <= addr_in;
            end
            if (start) begin
                oow_q <= ~in_win;
                cnt_q <= '0;
                if (in_win) begin
                    ram_addr_q <= ADDR_W'(BASE) + eff[ADDR_W-1:0];
                end
            end else if (active && !done) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign ram_addr = ram_addr_q;
    assign oow      = oow_q;

endmodule

// File: rtl/nvram_upload.sv
// Upload-side ioctl responder: halts the game CPU and returns bytes from a work-RAM window.
module nvram_upload
    import nvram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned BASE     = 0,
    parameter int unsigned LEN      = 64,
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned HALT_CYC = 16,
    parameter logic [7:0]  INDEX    = DEFAULT_INDEX
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    nvram_upload_if.slave     ioctl,
    output logic              ram_access,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic              busy
);

    if (!window_fits(ADDR_W, BASE, LEN) || RAM_LAT == 0 || RAM_LAT > 4 || HALT_CYC == 0)
    begin : g_bad_params
        $error("nvram_upload: window or latency parameters out of range");
    end

    nvram_state_e state_q, state_d;
    logic [15:0]  halt_cnt_q, halt_cnt_d;
    logic         req_q, req_d;
    logic [7:0]   din_q;
    logic         sel, rd, accept, start, done, oow;

    assign sel    = ioctl.ioctl_upload & (ioctl.ioctl_index == INDEX);
    assign rd     = sel & ioctl.ioctl_rd;
    assign accept = rd & ((state_q == StHalt) | (state_q == StReady));

    always_comb begin
        state_d    = state_q;
        halt_cnt_d = halt_cnt_q;
        start      = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel) begin
                    state_d    = StHalt;
                    halt_cnt_d = 16'(HALT_CYC - 1);
                end
            end
            StHalt: begin
                if (!sel) begin
                    state_d = StRelease;
                end else if (halt_cnt_q == '0) begin
                    start   = req_q | rd;
                    state_d = (req_q | rd) ? StFetch : StReady;
                end else begin
                    halt_cnt_d = halt_cnt_q - 16'd1;
                end
            end
            StReady: begin
                if (!sel) begin
                    state_d = StRelease;
                end else if (rd) begin
                    start   = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!sel) begin
                    state_d = StRelease;
                end else if (done) begin
                    state_d = StReady;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Dropping the session abandons any pending request.
    always_comb begin
        req_d = req_q;
        if (!sel) begin
            req_d = 1'b0;
        end else if (accept) begin
            req_d = 1'b1;
        end else if (done) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            halt_cnt_q <= '0;
            req_q      <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            halt_cnt_q <= halt_cnt_d;
            req_q      <= req_d;
            if (sel && done) begin
                din_q <= oow ? 8'hFF : ram_dout;
            end
        end
    end

    nvram_fetch #(
        .ADDR_W  (ADDR_W),
        .BASE    (BASE),
        .LEN     (LEN),
        .RAM_LAT (RAM_LAT)
    ) u_fetch (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .latch    (accept),
        .start    (start),
        .active   (state_q == StFetch),
        .addr_in  (ioctl.ioctl_addr),
        .ram_addr (ram_addr),
        .oow      (oow),
        .done     (done)
    );

    assign ioctl.ioctl_din  = din_q;
    assign ioctl.ioctl_wait = req_q;
    assign ram_access = (state_q == StHalt) | (state_q == StReady) | (state_q == StFetch);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_nvram_upload.sv
// Directed-plus-random bench for nvram_upload: two instances (RAM latency 1 and 4).
module tb_nvram_upload;

    localparam int unsigned AW     = 11;
    localparam int unsigned RAMSZ  = 1 << AW;
    localparam int unsigned LEN    = 64;
    localparam int unsigned HALT   = 16;
    localparam int unsigned BASE_A = 100;
    localparam int unsigned LAT_A  = 1;
    localparam int unsigned BASE_B = 1984;
    localparam int unsigned LAT_B  = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nvram_upload_if if_a ();
    nvram_upload_if if_b ();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [7:0]    ram_dout_a, ram_dout_b;
    logic          access_a, access_b, busy_a, busy_b;

    logic        drv_upload, drv_rd, use_b;
    logic [7:0]  drv_index;
    logic [24:0] drv_addr;

    assign if_a.ioctl_upload = drv_upload & ~use_b;
    assign if_a.ioctl_index  = drv_index;
    assign if_a.ioctl_rd     = drv_rd & ~use_b;
    assign if_a.ioctl_addr   = drv_addr;
    assign if_b.ioctl_upload = drv_upload & use_b;
    assign if_b.ioctl_index  = drv_index;
    assign if_b.ioctl_rd     = drv_rd & use_b;
    assign if_b.ioctl_addr   = drv_addr;

    nvram_upload #(
        .ADDR_W(AW), .BASE(BASE_A), .LEN(LEN), .RAM_LAT(LAT_A), .HALT_CYC(HALT), .INDEX(8'd4)
    ) u_dut_a (
        .clk_sys(clk), .reset_n(reset_n), .ioctl(if_a), .ram_access(access_a),
        .ram_addr(ram_addr_a), .ram_dout(ram_dout_a), .busy(busy_a)
    );

    nvram_upload #(
        .ADDR_W(AW), .BASE(BASE_B), .LEN(LEN), .RAM_LAT(LAT_B), .HALT_CYC(HALT), .INDEX(8'd4)
    ) u_dut_b (
        .clk_sys(clk), .reset_n(reset_n), .ioctl(if_b), .ram_access(access_b),
        .ram_addr(ram_addr_b), .ram_dout(ram_dout_b), .busy(busy_b)
    );

    // Work RAM shared by both instances; data returns RAM_LAT cycles after the address.
    logic [7:0]    mem [RAMSZ];
    logic [AW-1:0] pipe_b [3];
    always @(posedge clk) begin
        ram_dout_a <= mem[ram_addr_a];
        pipe_b[0]  <= ram_addr_b;
        pipe_b[1]  <= pipe_b[0];
        pipe_b[2]  <= pipe_b[1];
        ram_dout_b <= mem[pipe_b[2]];
    end

    logic [7:0]    o_din;
    logic          o_wait, o_access, o_busy;
    logic [AW-1:0] o_addr;
    assign o_din    = use_b ? if_b.ioctl_din  : if_a.ioctl_din;
    assign o_wait   = use_b ? if_b.ioctl_wait : if_a.ioctl_wait;
    assign o_access = use_b ? access_b        : access_a;
    assign o_busy   = use_b ? busy_b          : busy_a;
    assign o_addr   = use_b ? ram_addr_b      : ram_addr_a;

    int unsigned   cur_base, cur_lat;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_din;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] model_addr(input int unsigned base, input logic [24:0] off);
        return AW'((base + 32'(off)) % RAMSZ);
    endfunction

    function automatic logic [7:0] model_byte(input int unsigned base, input logic [24:0] off);
        if (off >= 25'(LEN)) return 8'hFF;
        return mem[model_addr(base, off)];
    endfunction

    // One request issued in READY; optionally a second, illegal request during the fetch.
    task automatic do_read(input logic [24:0] off, input bit poke);
        bit         inwin;
        int         nwait;
        logic [7:0] exp_din;
        inwin   = (off < 25'(LEN));
        nwait   = inwin ? int'(cur_lat) + 1 : 1;
        exp_din = model_byte(cur_base, off);
        drv_rd = 1'b1;
        drv_addr = off;
        tick();
        drv_rd = 1'b0;
        if (inwin) last_addr = model_addr(cur_base, off);
        chk("ram_addr", 32'(o_addr), 32'(last_addr));
        for (int k = 0; k < nwait; k++) begin
            chk("wait_high", 32'(o_wait), 32'd1);
            if (poke && k == 0) begin
                drv_rd = 1'b1;
                drv_addr = off ^ 25'h5;
            end
            tick();
            drv_rd = 1'b0;
        end
        chk("wait_low", 32'(o_wait), 32'd0);
        chk("din", 32'(o_din), 32'(exp_din));
        last_din = exp_din;
    endtask

    task automatic random_reads(input int n);
        logic [24:0] off;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) off = 25'($urandom);
            else off = 25'($urandom_range(0, LEN + 8));
            do_read(off, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                chk("gap_access", 32'(o_access), 32'd1);
                tick();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(RAMSZ); i++) mem[i] = 8'($urandom);
        mem[BASE_A + 5] = 8'hA7;
        drv_upload = 1'b0; drv_rd = 1'b0; drv_index = 8'd0; drv_addr = '0; use_b = 1'b0;
        cur_base = BASE_A; cur_lat = LAT_A; last_addr = '0; last_din = '0;
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_din", 32'(o_din), 32'd0);
        chk("rst_wait", 32'(o_wait), 32'd0);
        chk("rst_access", 32'(o_access), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Foreign index: nothing may react, requests included.
        drv_upload = 1'b1;
        drv_index = 8'd3;
        for (int c = 0; c < 24; c++) begin
            drv_rd = (c % 5 == 2);
            drv_addr = 25'(c);
            tick();
            chk("foreign_access", 32'(o_access), 32'd0);
            chk("foreign_busy", 32'(o_busy), 32'd0);
            chk("foreign_wait", 32'(o_wait), 32'd0);
        end
        drv_rd = 1'b0;
        drv_upload = 1'b0;
        tick();

        // Session on A, request for offset 0 at S+3 during the halt.
        drv_index = 8'd4;
        drv_upload = 1'b1;
        tick();
        for (int c = 1; c <= int'(HALT); c++) begin
            chk("halt_access", 32'(o_access), 32'd1);
            chk("halt_busy", 32'(o_busy), 32'd1);
            chk("halt_no_read", 32'(o_addr), 32'd0);
            chk("halt_wait", 32'(o_wait), 32'(c >= 4));
            drv_rd = (c == 3);
            drv_addr = '0;
            tick();
            drv_rd = 1'b0;
        end
        last_addr = model_addr(cur_base, 25'd0);
        chk("early_addr", 32'(o_addr), 32'(last_addr));
        chk("early_wait0", 32'(o_wait), 32'd1);
        tick();
        chk("early_wait1", 32'(o_wait), 32'd1);
        tick();
        chk("early_wait_low", 32'(o_wait), 32'd0);
        chk("early_din", 32'(o_din), 32'(mem[BASE_A]));
        last_din = mem[BASE_A];

        do_read(25'd5, 1'b0);
        do_read(25'd5, 1'b1);
        do_read(25'(LEN - 1), 1'b0);
        do_read(25'(LEN), 1'b0);
        do_read(25'h1FF_FFFF, 1'b0);
        random_reads(12);

        drv_upload = 1'b0;
        tick();
        chk("end_access", 32'(o_access), 32'd0);
        chk("end_wait", 32'(o_wait), 32'd0);
        chk("end_busy_f1", 32'(o_busy), 32'd1);
        tick();
        chk("end_busy_f2", 32'(o_busy), 32'd0);

        // Session on B: latency 4, window ending exactly at the top of RAM.
        use_b = 1'b1;
        cur_base = BASE_B; cur_lat = LAT_B; last_addr = '0; last_din = '0;
        drv_upload = 1'b1;
        tick();
        for (int c = 1; c <= int'(HALT); c++) begin
            chk("b_halt_access", 32'(o_access), 32'd1);
            tick();
        end
        do_read(25'(LEN - 1), 1'b0);
        do_read(25'd0, 1'b0);
        random_reads(6);
        do_read(25'(LEN + 3), 1'b0);

        // Abort mid-fetch, then re-raise the session during RELEASE.
        drv_rd = 1'b1;
        drv_addr = 25'd10;
        tick();
        drv_rd = 1'b0;
        chk("abort_wait_t1", 32'(o_wait), 32'd1);
        chk("abort_addr_t1", 32'(o_addr), 32'(model_addr(cur_base, 25'd10)));
        tick();
        drv_upload = 1'b0;
        tick();
        chk("abort_access", 32'(o_access), 32'd0);
        chk("abort_wait", 32'(o_wait), 32'd0);
        chk("abort_din", 32'(o_din), 32'(last_din));
        drv_upload = 1'b1;
        tick();
        chk("rerise_busy_f2", 32'(o_busy), 32'd0);
        chk("rerise_access_f2", 32'(o_access), 32'd0);
        tick();
        chk("rerise_access_f3", 32'(o_access), 32'd1);
        chk("rerise_din", 32'(o_din), 32'(last_din));
        for (int c = 0; c < int'(HALT); c++) tick();

        // Asynchronous reset in the middle of a fetch.
        drv_rd = 1'b1;
        drv_addr = 25'd7;
        tick();
        drv_rd = 1'b0;
        tick();
        chk("pre_rst_wait", 32'(o_wait), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_din", 32'(o_din), 32'd0);
        chk("arst_wait", 32'(o_wait), 32'd0);
        chk("arst_access", 32'(o_access), 32'd0);
        chk("arst_addr", 32'(o_addr), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        drv_upload = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        chk("post_rst_access", 32'(o_access), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
